// File: rtl/ladybird_pkg.sv
// Shared ladybird FIFO types: per-cycle push/pop operation encoding and a ceil-log2 helper.
package ladybird_pkg;

  typedef enum logic [1:0] {OP_NONE, OP_R, OP_W, OP_WR} fifo_op_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ladybird_fifo_outreg.sv
// One-entry valid/ready register stage with flush; data and valid come straight from flops.
// Accepts a new entry when empty or when the held entry is taken in the same cycle.
module ladybird_fifo_outreg
  import ladybird_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;

  assign in_ready_o  = ~vld_q | out_ready_i;
  assign out_valid_o = vld_q;
  assign out_data_o  = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_valid_i && in_ready_o) begin
      vld_d = 1'b1;
      dat_d = in_data_i;
    end else if (out_ready_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (!nrst_i || flush_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/ladybird_level_fifo.sv
// Level-reporting FIFO: push at edge N is visible on b_valid after edge N (no write-to-read bypass);
// a_ready/b_valid depend on registers only, so neither side sees a combinational path from the other.
module ladybird_level_fifo
  import ladybird_pkg::*;
#(
  parameter int DEPTH_W   = 5,
  parameter int DATA_W    = 8,
  parameter int AF_THRESH = (2 ** DEPTH_W) - 2,
  parameter int AE_THRESH = 1,
  parameter int OUT_REG   = 0
) (
  input  logic              clk,
  input  logic              anrst,
  input  logic              nrst_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  output logic [DATA_W-1:0] b_data_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  output logic [DEPTH_W:0]  count_o,
  output logic              almost_full_o,
  output logic              almost_empty_o
);

  typedef logic [DEPTH_W:0] cnt_t;

  localparam int RAM_D = 2 ** DEPTH_W;
  localparam int CAP   = RAM_D + ((OUT_REG != 0) ? 1 : 0);
  localparam int AF_C  = (AF_THRESH < 0) ? 0 : ((AF_THRESH > CAP) ? CAP : AF_THRESH);
  localparam int AE_C  = (AE_THRESH < 0) ? 0 : ((AE_THRESH > CAP) ? CAP : AE_THRESH);
  localparam cnt_t CAP_V = cnt_t'(CAP);
  localparam cnt_t AF_V  = cnt_t'(AF_C);
  localparam cnt_t AE_V  = cnt_t'(AE_C);

  if (AF_THRESH < 0 || AF_THRESH > CAP) begin : g_af_range
    $error("ladybird_level_fifo: AF_THRESH outside [0, CAP], clamped");
  end
  if (AE_THRESH < 0 || AE_THRESH > CAP) begin : g_ae_range
    $error("ladybird_level_fifo: AE_THRESH outside [0, CAP], clamped");
  end

  cnt_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [DATA_W-1:0] mem_q [RAM_D];
  logic [DATA_W-1:0] ram_head;
  logic              push, pop, ram_wr, ram_rd, ram_empty;
  fifo_op_t          op;

  // Pointers carry a wrap bit: equal means empty, so the output-reg path never reads stale RAM.
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_head  = mem_q[rd_ptr_q[DEPTH_W-1:0]];

  assign a_ready_o      = (count_q != CAP_V);
  assign push           = a_valid_i & a_ready_o;
  assign pop            = b_valid_o & b_ready_i;
  assign op             = fifo_op_t'({push, pop});
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= AF_V);
  assign almost_empty_o = (count_q <= AE_V);

  if (OUT_REG != 0) begin : g_oreg
    logic              or_in_rdy;
    logic [DATA_W-1:0] or_in_dat;

    // With the RAM empty the head register takes the incoming word directly.
    assign or_in_dat = ram_empty ? a_data_i : ram_head;
    assign ram_rd    = or_in_rdy & ~ram_empty;
    assign ram_wr    = push & ~(ram_empty & or_in_rdy);

    ladybird_fifo_outreg #(.DATA_W(DATA_W)) u_outreg (
      .clk         (clk),
      .anrst       (anrst),
      .nrst_i      (nrst_i),
      .flush_i     (flush_i),
      .in_data_i   (or_in_dat),
      .in_valid_i  (push | ~ram_empty),
      .in_ready_o  (or_in_rdy),
      .out_data_o  (b_data_o),
      .out_valid_o (b_valid_o),
      .out_ready_i (b_ready_i)
    );
  end else begin : g_noreg
    assign b_data_o  = ram_head;
    assign b_valid_o = ~ram_empty;
    assign ram_rd    = pop;
    assign ram_wr    = push;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + cnt_t'(ram_wr);
    rd_ptr_d = rd_ptr_q + cnt_t'(ram_rd);
    count_d  = count_q;
    case (op)
      OP_W:    count_d = count_q + cnt_t'(1);
      OP_R:    count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RAM_D; i++) mem_q[i] <= '0;
    end else if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RAM_D; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (ram_wr) mem_q[wr_ptr_q[DEPTH_W-1:0]] <= a_data_i;
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!anrst) count_q <= CAP_V)
    else $error("ladybird_level_fifo: count above capacity or wrapped below zero");

endmodule
